sha1_job_arbiter: RTL and testbench

// - Shares one SHA1_hash core among NUM_REQ requesters. Per-requester valid/ready job queue (addr, size) is

---
 rtl/sha1_arb_pkg.sv | 25 ++
 rtl/sha1_job_arbiter_rr_picker.sv | 33 +++
 rtl/sha1_job_arbiter.sv | 153 +++++++++++++++
 tb/tb_sha1_job_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sha1_arb_pkg.sv
// Shared types and constants for the SHA-1 job arbiter.
package sha1_arb_pkg;

    localparam int DIGEST_W = 160;
    localparam int ADDR_W   = 32;
    localparam int SIZE_W   = 32;

    // SHA-1 initial hash values, handy for benches that model the core.
    localparam logic [31:0] SHA1_H0 = 32'h67452301;
    localparam logic [31:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [31:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [31:0] SHA1_H3 = 32'h10325476;
    localparam logic [31:0] SHA1_H4 = 32'hC3D2E1F0;
    localparam logic [DIGEST_W-1:0] SHA1_IV = {SHA1_H0, SHA1_H1, SHA1_H2, SHA1_H3, SHA1_H4};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_GUARD,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/sha1_job_arbiter_rr_picker.sv
// Round-robin picker: first set request bit at or above ptr_i, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int          j;
    logic [PW-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j  = (int'(ptr_i) + k) % N;
            jj = PW'(j);
            if (!any_o && req_i[jj]) begin
                any_o     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/sha1_job_arbiter.sv
// Shares one SHA-1 core among NUM_REQ requesters; one job in flight, round-robin grant,
// digest or error returned to the job owner.
module sha1_job_arbiter
    import sha1_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_MSG_BYTES  = 16384,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [SIZE_W*NUM_REQ-1:0] req_size,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DIGEST_W-1:0]       rsp_hash,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic [ADDR_W-1:0]         core_addr,
    output logic [SIZE_W-1:0]         core_size,
    input  logic                      core_done,
    input  logic [DIGEST_W-1:0]       core_hash,
    output logic                      busy
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         owner_q, owner_d, rr_q, rr_d;
    logic [NUM_REQ-1:0]    oh_q, oh_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic [DIGEST_W-1:0]   hash_q, hash_d;
    logic                  err_q, err_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;

    logic [ADDR_W-1:0]     addr_arr [NUM_REQ];
    logic [SIZE_W-1:0]     size_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    pick_gnt;
    logic [PW-1:0]         pick_idx;
    logic                  pick_any;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign size_arr[g] = req_size[g*SIZE_W +: SIZE_W];
    end

    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        oh_d    = oh_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        size_d  = size_q;
        hash_d  = hash_q;
        err_d   = err_q;
        gcnt_d  = gcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: if (pick_any) begin
                owner_d = pick_idx;
                oh_d    = pick_gnt;
                addr_d  = addr_arr[pick_idx];
                size_d  = size_arr[pick_idx];
                state_d = ST_GRANT;
            end
            ST_GRANT: if (size_q > SIZE_W'(MAX_MSG_BYTES)) begin
                err_d   = 1'b1;
                hash_d  = '0;
                state_d = ST_RESP;
            end else begin
                state_d = ST_START;
            end
            ST_START: begin
                gcnt_d  = '0;
                state_d = ST_GUARD;
            end
            // core_done may still be high from the previous job; do not look at it here.
            ST_GUARD: if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                tcnt_d  = '0;
                state_d = ST_WAIT;
            end else begin
                gcnt_d = gcnt_q + GW'(1);
            end
            ST_WAIT: if (core_done) begin
                hash_d  = core_hash;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                hash_d  = '0;
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
            ST_RESP: if (|(rsp_ready & oh_q)) begin
                rr_d    = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            oh_q    <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            hash_q  <= '0;
            err_q   <= 1'b0;
            gcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            oh_q    <= oh_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            hash_q  <= hash_d;
            err_q   <= err_d;
            gcnt_q  <= gcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign req_ready  = (state_q == ST_GRANT) ? oh_q : '0;
    assign rsp_valid  = (state_q == ST_RESP) ? oh_q : '0;
    assign rsp_hash   = (state_q == ST_RESP) ? hash_q : '0;
    assign rsp_err    = (state_q == ST_RESP) && err_q;
    assign core_start = (state_q == ST_START);
    assign core_addr  = addr_q;
    assign core_size  = size_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha1_job_arbiter.sv
// Directed bench for sha1_job_arbiter; the bench plays the SHA-1 core by hand.
module tb_sha1_job_arbiter;

    logic         clk = 1'b0;
    logic         nreset;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_addr, req_size;
    logic [31:0]  addr_r [4];
    logic [31:0]  size_r [4];
    logic [159:0] rsp_hash, core_hash;
    logic         rsp_err, core_start, core_done, busy;
    logic [31:0]  core_addr, core_size;

    int checks = 0;
    int errors = 0;

    localparam logic [159:0] ABC_DIGEST = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

    assign req_addr = {addr_r[3], addr_r[2], addr_r[1], addr_r[0]};
    assign req_size = {size_r[3], size_r[2], size_r[1], size_r[0]};

    always #5 clk = ~clk;

    sha1_job_arbiter #(
        .NUM_REQ(4), .MAX_MSG_BYTES(16384), .TIMEOUT_CYCLES(100), .GUARD_CYCLES(2)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hash(rsp_hash), .rsp_err(rsp_err),
        .core_start(core_start), .core_addr(core_addr), .core_size(core_size),
        .core_done(core_done), .core_hash(core_hash), .busy(busy)
    );

    typedef struct {
        logic [1:0]   idx;
        logic [31:0]  addr;
        logic [31:0]  size;
        int           dly;       // cycles after START before done; 0 = never
        logic [159:0] hash;
        logic         exp_start;
        logic         exp_err;
        logic [159:0] exp_hash;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        @(negedge clk);
        addr_r[v.idx]    = v.addr;
        size_r[v.idx]    = v.size;
        req_valid[v.idx] = 1'b1;
        @(negedge clk);
        chk("grant", {busy, req_ready}, {1'b1, 4'b0001 << v.idx});
        @(negedge clk);
        req_valid[v.idx] = 1'b0;
        chk("start", core_start, v.exp_start);
        if (v.exp_start) begin
            chk("core_addr", core_addr, v.addr);
            chk("core_size", core_size, v.size);
            if (v.dly > 0) begin
                repeat (v.dly) @(negedge clk);
                core_done = 1'b1;
                core_hash = v.hash;
                @(negedge clk);
                core_done = 1'b0;
            end else begin
                repeat (102) @(negedge clk);
                chk("tmo_early", rsp_valid, 4'b0);
                @(negedge clk);
            end
        end
        chk("rsp_valid", rsp_valid, 4'b0001 << v.idx);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_hash", rsp_hash, v.exp_hash);
        rsp_ready[v.idx] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        chk("idle", {busy, rsp_valid}, 5'b0);
    endtask

    initial begin
        int n;
        tv[0] = '{2'd0, 32'h0000_0000, 32'd3,     3,  ABC_DIGEST,          1'b1, 1'b0, ABC_DIGEST};
        tv[1] = '{2'd1, 32'h0000_1000, 32'd64,    5,  {5{32'h1111_2222}},  1'b1, 1'b0, {5{32'h1111_2222}}};
        tv[2] = '{2'd2, 32'h0000_2000, 32'd16385, 3,  {5{32'hDEAD_BEEF}},  1'b0, 1'b1, 160'h0};
        tv[3] = '{2'd3, 32'h0000_3000, 32'd16384, 4,  {5{32'h3333_4444}},  1'b1, 1'b0, {5{32'h3333_4444}}};
        tv[4] = '{2'd1, 32'h0000_4000, 32'd0,     10, {5{32'h5555_6666}},  1'b1, 1'b0, {5{32'h5555_6666}}};
        tv[5] = '{2'd0, 32'h0000_5000, 32'd100,   0,  {5{32'h7777_8888}},  1'b1, 1'b1, 160'h0};

        nreset = 1'b0; req_valid = '0; rsp_ready = '0; core_done = 1'b0; core_hash = '0;
        for (int i = 0; i < 4; i++) begin addr_r[i] = '0; size_r[i] = '0; end
        @(negedge clk);
        chk("reset_outs", {req_ready, rsp_valid, rsp_err, core_start, busy, core_addr, core_size}, '0);
        chk("reset_hash", rsp_hash, '0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 6; i++) run_job(tv[i]);

        // Stale done held through START/GUARD, then backpressure with non-owner readies.
        addr_r[2] = 32'h2200; size_r[2] = 32'd55;
        core_done = 1'b1; core_hash = {5{32'h5A1E_5A1E}};
        @(negedge clk); req_valid[2] = 1'b1;
        @(negedge clk); chk("stale_grant", req_ready, 4'b0100);
        @(negedge clk); req_valid = '0; chk("stale_start", core_start, 1'b1);
        repeat (3) @(negedge clk);
        core_done = 1'b0;
        chk("stale_ignored", rsp_valid, 4'b0);
        repeat (2) @(negedge clk);
        core_done = 1'b1; core_hash = {5{32'hF2E5_F2E5}};
        @(negedge clk);
        core_done = 1'b0; core_hash = '0;
        rsp_ready = 4'b1011;
        for (int c = 0; c < 20; c++) begin
            chk("bp_hold", {rsp_valid, rsp_err, rsp_hash}, {4'b0100, 1'b0, {5{32'hF2E5_F2E5}}});
            @(negedge clk);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
        chk("bp_release", {busy, rsp_valid}, 5'b0);

        // Reset in the middle of WAIT_DONE.
        addr_r[1] = 32'h9000; size_r[1] = 32'd10;
        @(negedge clk); req_valid[1] = 1'b1;
        @(negedge clk);
        @(negedge clk); req_valid = '0;
        repeat (4) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        nreset = 1'b0;
        #1;
        chk("midrst_outs", {req_ready, rsp_valid, rsp_err, core_start, busy, core_addr, core_size}, '0);
        chk("midrst_hash", rsp_hash, '0);
        @(negedge clk);
        nreset = 1'b1;

        // Fairness with all requesters valid; pointer restarts at 0 after reset.
        for (int i = 0; i < 4; i++) begin addr_r[i] = 32'h100 * i; size_r[i] = 32'd8; end
        @(negedge clk); req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            @(negedge clk);
            while (req_ready == 4'b0 && n < 8) begin @(negedge clk); n++; end
            chk("fair_grant", req_ready, 4'b0001 << (k % 4));
            @(negedge clk);
            chk("fair_addr", core_addr, 32'h100 * (k % 4));
            repeat (3) @(negedge clk);
            core_done = 1'b1; core_hash = {5{32'hC0DE_0000 | 32'(k)}};
            @(negedge clk);
            core_done = 1'b0;
            chk("fair_rsp", {rsp_valid, rsp_hash}, {4'b0001 << (k % 4), {5{32'hC0DE_0000 | 32'(k)}}});
            rsp_ready = 4'hF;
            @(negedge clk);
            rsp_ready = '0;
        end
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
